// File: rtl/cricket_match_ctrl.sv
// -----------------------------------------------------------------------------
// cricket_match_ctrl
//
// Two-innings limited-overs match controller. It takes one scored delivery per
// cycle, keeps the innings score, wickets and over/ball position, and ends each
// innings on all-out, overs exhausted, or (second innings only) target reached.
// Once the second innings ends it resolves the result as a win, loss or tie.
//
// Parameters:
//   OVERS          overs per innings
//   BALLS_PER_OVER legal balls per over
//   MAX_WICKETS    wickets that end an innings
//   RUN_W          score width; the score saturates at 2^RUN_W-1
//
// Ports:
//   clk, rst       clock (rising edge) and asynchronous active-high reset
//   play           start/resume request; only a rising edge acts
//   ball_valid     a delivery is presented this cycle
//   ball_runs      runs off the bat, 0..6 (7 is treated as 6)
//   ball_wicket    a wicket fell on this delivery (ignored on extras)
//   ball_extra     wide/no-ball: one penalty run, not a legal ball
//   batting_team   0 = team 1 batting, 1 = team 2 batting
//   runs, wickets  current innings score and wickets
//   ball_count     legal balls bowled this innings
//   over_count     completed overs this innings
//   ball_in_over   legal balls into the current over
//   target         team 1 final score + 1 (saturating), 0 before the break
//   innings_over   high in BREAK or DONE
//   game_over      high in DONE
//   winner         00 undecided, 01 team 1, 10 team 2, 11 tie
// -----------------------------------------------------------------------------
module cricket_match_ctrl #(
  parameter int OVERS          = 20,
  parameter int BALLS_PER_OVER = 6,
  parameter int MAX_WICKETS    = 10,
  parameter int RUN_W          = 9,
  localparam int TOTAL_BALLS   = OVERS * BALLS_PER_OVER,
  localparam int BC_W          = $clog2(TOTAL_BALLS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             play,
  input  logic             ball_valid,
  input  logic [2:0]       ball_runs,
  input  logic             ball_wicket,
  input  logic             ball_extra,
  output logic             batting_team,
  output logic [RUN_W-1:0] runs,
  output logic [3:0]       wickets,
  output logic [BC_W-1:0]  ball_count,
  output logic [5:0]       over_count,
  output logic [2:0]       ball_in_over,
  output logic [RUN_W-1:0] target,
  output logic             innings_over,
  output logic             game_over,
  output logic [1:0]       winner
);

  // Headroom for the largest single-ball increment (6 runs + 1 penalty).
  localparam int               SUM_W   = RUN_W + 3;
  localparam logic [RUN_W-1:0] RUN_MAX = {RUN_W{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INN1  = 3'd1,
    S_BREAK = 3'd2,
    S_INN2  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t           state_reg, state_next;
  logic             play_q_reg;
  logic             batting_reg, batting_next;
  logic [RUN_W-1:0] runs_reg, runs_next;
  logic [RUN_W-1:0] target_reg, target_next;
  logic [3:0]       wickets_reg, wickets_next;
  logic [BC_W-1:0]  ball_count_reg, ball_count_next;
  logic [5:0]       over_count_reg, over_count_next;
  logic [2:0]       ball_in_over_reg, ball_in_over_next;
  logic [1:0]       winner_reg, winner_next;

  // Post-delivery values, used both for the register update and for the
  // termination test so that both see the same edge's result.
  logic             start;
  logic [2:0]       runs_eff;
  logic [SUM_W-1:0] runs_sum;
  logic [RUN_W-1:0] runs_upd;
  logic [RUN_W-1:0] target_upd;
  logic [3:0]       wickets_upd;
  logic [BC_W-1:0]  ball_count_upd;
  logic [5:0]       over_count_upd;
  logic [2:0]       ball_in_over_upd;
  logic             end_by_wickets;
  logic             end_by_balls;
  logic             end_by_chase;
  logic [1:0]       result;

  always_comb begin
    start    = play & ~play_q_reg;
    runs_eff = (ball_runs == 3'd7) ? 3'd6 : ball_runs;
    runs_sum = SUM_W'(runs_reg) + SUM_W'(runs_eff) + SUM_W'(ball_extra);
    runs_upd = (runs_sum > SUM_W'(RUN_MAX)) ? RUN_MAX : runs_sum[RUN_W-1:0];
    target_upd = (runs_upd == RUN_MAX) ? RUN_MAX : runs_upd + RUN_W'(1);

    wickets_upd      = wickets_reg;
    ball_count_upd   = ball_count_reg;
    over_count_upd   = over_count_reg;
    ball_in_over_upd = ball_in_over_reg;
    if (!ball_extra) begin
      wickets_upd    = wickets_reg + 4'(ball_wicket);
      ball_count_upd = ball_count_reg + BC_W'(1);
      if (ball_in_over_reg == 3'(BALLS_PER_OVER - 1)) begin
        ball_in_over_upd = 3'd0;
        over_count_upd   = over_count_reg + 6'd1;
      end else begin
        ball_in_over_upd = ball_in_over_reg + 3'd1;
      end
    end

    end_by_wickets = (wickets_upd == 4'(MAX_WICKETS));
    end_by_balls   = (ball_count_upd == BC_W'(TOTAL_BALLS));
    // Only meaningful in the second innings; target is 0 during the first.
    end_by_chase   = (runs_upd >= target_reg);

    if (runs_upd >= target_reg) begin
      result = 2'b10;
    end else if (runs_upd == target_reg - RUN_W'(1)) begin
      result = 2'b11;
    end else begin
      result = 2'b01;
    end
  end

  always_comb begin
    state_next        = state_reg;
    batting_next      = batting_reg;
    runs_next         = runs_reg;
    target_next       = target_reg;
    wickets_next      = wickets_reg;
    ball_count_next   = ball_count_reg;
    over_count_next   = over_count_reg;
    ball_in_over_next = ball_in_over_reg;
    winner_next       = winner_reg;

    case (state_reg)
      S_IDLE: begin
        if (start) begin
          state_next        = S_INN1;
          batting_next      = 1'b0;
          runs_next         = '0;
          target_next       = '0;
          wickets_next      = '0;
          ball_count_next   = '0;
          over_count_next   = '0;
          ball_in_over_next = '0;
          winner_next       = 2'b00;
        end
      end

      S_INN1, S_INN2: begin
        if (ball_valid) begin
          runs_next         = runs_upd;
          wickets_next      = wickets_upd;
          ball_count_next   = ball_count_upd;
          over_count_next   = over_count_upd;
          ball_in_over_next = ball_in_over_upd;
          if (state_reg == S_INN1) begin
            if (end_by_wickets || end_by_balls) begin
              state_next  = S_BREAK;
              target_next = target_upd;
            end
          end else begin
            if (end_by_wickets || end_by_balls || end_by_chase) begin
              state_next  = S_DONE;
              winner_next = result;
            end
          end
        end
      end

      // Any delivery presented here, even alongside start, is dropped.
      S_BREAK: begin
        if (start) begin
          state_next        = S_INN2;
          batting_next      = 1'b1;
          runs_next         = '0;
          wickets_next      = '0;
          ball_count_next   = '0;
          over_count_next   = '0;
          ball_in_over_next = '0;
        end
      end

      S_DONE: begin
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg        <= S_IDLE;
      play_q_reg       <= 1'b0;
      batting_reg      <= 1'b0;
      runs_reg         <= '0;
      target_reg       <= '0;
      wickets_reg      <= '0;
      ball_count_reg   <= '0;
      over_count_reg   <= '0;
      ball_in_over_reg <= '0;
      winner_reg       <= 2'b00;
    end else begin
      state_reg        <= state_next;
      play_q_reg       <= play;
      batting_reg      <= batting_next;
      runs_reg         <= runs_next;
      target_reg       <= target_next;
      wickets_reg      <= wickets_next;
      ball_count_reg   <= ball_count_next;
      over_count_reg   <= over_count_next;
      ball_in_over_reg <= ball_in_over_next;
      winner_reg       <= winner_next;
    end
  end

  assign batting_team = batting_reg;
  assign runs         = runs_reg;
  assign wickets      = wickets_reg;
  assign ball_count   = ball_count_reg;
  assign over_count   = over_count_reg;
  assign ball_in_over = ball_in_over_reg;
  assign target       = target_reg;
  assign innings_over = (state_reg == S_BREAK) || (state_reg == S_DONE);
  assign game_over    = (state_reg == S_DONE);
  assign winner       = winner_reg;

endmodule

// File: tb/tb_cricket_match_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cricket_match_ctrl
//
// Drives two controllers from the same stimulus: one with default parameters
// and one small configuration (2 overs, 6 balls, 2 wickets, 4-bit score) so
// that saturation, all-out and chase endings occur often. A match-level model
// (phase number, score, legal-ball tally) predicts every output each cycle.
// -----------------------------------------------------------------------------
module tb_cricket_match_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       play;
  logic       ball_valid;
  logic [2:0] ball_runs;
  logic       ball_wicket;
  logic       ball_extra;

  always #5 clk = ~clk;

  // Default-parameter instance outputs
  logic       a_batting, a_io, a_go;
  logic [8:0] a_runs, a_tgt;
  logic [3:0] a_wk;
  logic [6:0] a_bc;
  logic [5:0] a_oc;
  logic [2:0] a_bio;
  logic [1:0] a_win;

  // Small instance outputs
  logic       b_batting, b_io, b_go;
  logic [3:0] b_runs, b_tgt;
  logic [3:0] b_wk;
  logic [3:0] b_bc;
  logic [5:0] b_oc;
  logic [2:0] b_bio;
  logic [1:0] b_win;

  cricket_match_ctrl u_dut_def (
    .clk(clk), .rst(rst), .play(play), .ball_valid(ball_valid),
    .ball_runs(ball_runs), .ball_wicket(ball_wicket), .ball_extra(ball_extra),
    .batting_team(a_batting), .runs(a_runs), .wickets(a_wk),
    .ball_count(a_bc), .over_count(a_oc), .ball_in_over(a_bio),
    .target(a_tgt), .innings_over(a_io), .game_over(a_go), .winner(a_win)
  );

  cricket_match_ctrl #(
    .OVERS(2), .BALLS_PER_OVER(6), .MAX_WICKETS(2), .RUN_W(4)
  ) u_dut_small (
    .clk(clk), .rst(rst), .play(play), .ball_valid(ball_valid),
    .ball_runs(ball_runs), .ball_wicket(ball_wicket), .ball_extra(ball_extra),
    .batting_team(b_batting), .runs(b_runs), .wickets(b_wk),
    .ball_count(b_bc), .over_count(b_oc), .ball_in_over(b_bio),
    .target(b_tgt), .innings_over(b_io), .game_over(b_go), .winner(b_win)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input int got, input int exp_v);
    n_checks++;
    if (got == exp_v) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp_v);
  endtask

  // ---------------- reference model ----------------
  // Phases: 0 idle, 1 first innings, 2 break, 3 second innings, 4 done.
  int p_overs [2] = '{20, 2};
  int p_bpo   [2] = '{6, 6};
  int p_mw    [2] = '{10, 2};
  int p_max   [2] = '{511, 15};

  int m_phase [2];
  int m_runs  [2];
  int m_wk    [2];
  int m_legal [2];
  int m_tgt   [2];
  int m_win   [2];
  bit m_play_q;

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_phase[i] = 0; m_runs[i] = 0; m_wk[i] = 0;
      m_legal[i] = 0; m_tgt[i] = 0;  m_win[i] = 0;
    end
    m_play_q = 1'b0;
  endfunction

  function automatic void model_step(int i, bit st, bit v, int r, bit w, bit x);
    bit fin;
    fin = 1'b0;
    case (m_phase[i])
      0: if (st) begin
           m_phase[i] = 1; m_runs[i] = 0; m_wk[i] = 0; m_legal[i] = 0; m_tgt[i] = 0;
         end
      1, 3: if (v) begin
           m_runs[i] = m_runs[i] + ((r > 6) ? 6 : r) + int'(x);
           if (m_runs[i] > p_max[i]) m_runs[i] = p_max[i];
           if (!x) begin
             m_legal[i]++;
             m_wk[i] += int'(w);
           end
           fin = (m_wk[i] == p_mw[i]) || (m_legal[i] == p_overs[i] * p_bpo[i]) ||
                 (m_phase[i] == 3 && m_runs[i] >= m_tgt[i]);
           if (fin && m_phase[i] == 1) begin
             m_phase[i] = 2;
             m_tgt[i] = (m_runs[i] + 1 > p_max[i]) ? p_max[i] : m_runs[i] + 1;
           end else if (fin) begin
             m_phase[i] = 4;
             if (m_runs[i] >= m_tgt[i])          m_win[i] = 2;
             else if (m_runs[i] == m_tgt[i] - 1) m_win[i] = 3;
             else                                m_win[i] = 1;
           end
         end
      2: if (st) begin
           m_phase[i] = 3; m_runs[i] = 0; m_wk[i] = 0; m_legal[i] = 0;
         end
      default: ;
    endcase
  endfunction

  string tags [10] = '{"batting_team", "runs", "wickets", "ball_count", "over_count",
                       "ball_in_over", "target", "innings_over", "game_over", "winner"};

  task automatic check_both();
    int act [10];
    int exp_v [10];
    string pre;
    for (int i = 0; i < 2; i++) begin
      if (i == 0) begin
        pre = "def.";
        act = '{int'(a_batting), int'(a_runs), int'(a_wk), int'(a_bc), int'(a_oc),
                int'(a_bio), int'(a_tgt), int'(a_io), int'(a_go), int'(a_win)};
      end else begin
        pre = "small.";
        act = '{int'(b_batting), int'(b_runs), int'(b_wk), int'(b_bc), int'(b_oc),
                int'(b_bio), int'(b_tgt), int'(b_io), int'(b_go), int'(b_win)};
      end
      exp_v[0] = (m_phase[i] >= 3) ? 1 : 0;
      exp_v[1] = m_runs[i];
      exp_v[2] = m_wk[i];
      exp_v[3] = m_legal[i];
      exp_v[4] = m_legal[i] / p_bpo[i];
      exp_v[5] = m_legal[i] % p_bpo[i];
      exp_v[6] = m_tgt[i];
      exp_v[7] = (m_phase[i] == 2 || m_phase[i] == 4) ? 1 : 0;
      exp_v[8] = (m_phase[i] == 4) ? 1 : 0;
      exp_v[9] = (m_phase[i] == 4) ? m_win[i] : 0;
      for (int k = 0; k < 10; k++) check_eq({pre, tags[k]}, act[k], exp_v[k]);
    end
  endtask

  // ---------------- stimulus helpers ----------------
  bit play_lvl = 1'b0;
  bit verbose  = 1'b1;

  // Called at a falling edge: apply inputs, let one rising edge pass, update
  // the model, then check at the next falling edge.
  task automatic cycle(input bit p, input bit v, input int r, input bit w, input bit x);
    bit st;
    play = p; ball_valid = v; ball_runs = 3'(r); ball_wicket = w; ball_extra = x;
    @(posedge clk);
    st = p & ~m_play_q;
    m_play_q = p;
    model_step(0, st, v, r, w, x);
    model_step(1, st, v, r, w, x);
    @(negedge clk);
    if (verbose)
      $display("tx play=%0b valid=%0b runs_in=%0d wkt=%0b extra=%0b | def %0d/%0d b%0d | small %0d/%0d b%0d win%0d",
               p, v, r, w, x, a_runs, a_wk, a_bc, b_runs, b_wk, b_bc, b_win);
    check_both();
  endtask

  task automatic ball(input int r, input bit w, input bit x);
    cycle(play_lvl, 1'b1, r, w, x);
  endtask

  task automatic press_play();
    play_lvl = 1'b0; cycle(1'b0, 1'b0, 0, 1'b0, 1'b0);
    play_lvl = 1'b1; cycle(1'b1, 1'b0, 0, 1'b0, 1'b0);
  endtask

  // Asserts reset between edges and checks the outputs clear before any edge.
  task automatic do_reset();
    play_lvl = 1'b0; play = 1'b0; ball_valid = 1'b0;
    #2 rst = 1'b1;
    #1 model_reset();
    check_both();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; play = 1'b0; ball_valid = 1'b0;
    ball_runs = 3'd0; ball_wicket = 1'b0; ball_extra = 1'b0;
    model_reset();
    @(negedge clk);
    check_both();
    rst = 1'b0;

    // Game A: play held high through the first innings; an extra with a
    // wicket flag; small side sets 10, second innings chases with 6 + 6.
    play_lvl = 1'b1;
    cycle(1'b1, 1'b0, 0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) ball(1, 1'b0, 1'b0);
    ball(4, 1'b1, 1'b1);
    check_eq("extra_runs", int'(b_runs), 10);
    check_eq("extra_wkts", int'(b_wk), 0);
    for (int k = 0; k < 7; k++) ball(0, 1'b0, 1'b0);
    check_eq("inn1_target", int'(b_tgt), 11);
    ball(2, 1'b0, 1'b0);
    ball(3, 1'b0, 1'b0);
    check_eq("held_play_break", int'(b_io), 1);
    check_eq("held_play_team", int'(b_batting), 0);
    press_play();
    ball(6, 1'b0, 1'b0);
    ball(7, 1'b0, 1'b0);
    check_eq("chase_runs", int'(b_runs), 12);
    check_eq("chase_winner", int'(b_win), 2);
    for (int k = 0; k < 3; k++) ball(5, 1'b1, 1'b0);
    check_eq("done_hold", int'(b_runs), 12);

    // Game B: all-out on balls 3 and 4, then a tie at 10.
    do_reset();
    press_play();
    ball(2, 1'b0, 1'b0); ball(2, 1'b0, 1'b0);
    ball(3, 1'b1, 1'b0); ball(3, 1'b1, 1'b0);
    check_eq("allout_bc", int'(b_bc), 4);
    check_eq("allout_bio", int'(b_bio), 4);
    press_play();
    for (int k = 0; k < 10; k++) ball(1, 1'b0, 1'b0);
    ball(0, 1'b0, 1'b0);
    ball(0, 1'b0, 1'b0);
    check_eq("tie_winner", int'(b_win), 3);

    // Game C: same first innings, second innings short by two.
    do_reset();
    press_play();
    ball(2, 1'b0, 1'b0); ball(2, 1'b0, 1'b0);
    ball(3, 1'b1, 1'b0); ball(3, 1'b1, 1'b0);
    press_play();
    for (int k = 0; k < 9; k++) ball(1, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) ball(0, 1'b0, 1'b0);
    check_eq("loss_winner", int'(b_win), 1);

    // Game D: full 20-over innings of singles on the default instance.
    do_reset();
    press_play();
    for (int k = 0; k < 120; k++) ball(1, 1'b0, 1'b0);
    check_eq("t20_runs", int'(a_runs), 120);
    check_eq("t20_overs", int'(a_oc), 20);
    check_eq("t20_target", int'(a_tgt), 121);
    check_eq("t20_break", int'(a_io), 1);

    // Randomized play with resets mid-match.
    verbose = 1'b0;
    for (int seg = 0; seg < 4; seg++) begin
      do_reset();
      for (int c = 0; c < 700; c++) begin
        if ($urandom_range(0, 15) == 0) play_lvl = ~play_lvl;
        cycle(play_lvl, ($urandom_range(0, 3) != 0), int'($urandom_range(0, 7)),
              ($urandom_range(0, 15) == 0), ($urandom_range(0, 9) == 0));
      end
      $display("segment %0d: def phase %0d runs %0d | small phase %0d runs %0d win %0d",
               seg, m_phase[0], m_runs[0], m_phase[1], m_runs[1], m_win[1]);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cricket_match_ctrl.md
Name: cricket_match_ctrl

Overview:
Parametrised two-innings limited-overs match controller. It is the successor to the fixed T20 game controller and is configurable in overs, balls per over, wicket limit and score width. It accepts one scored delivery per cycle, including extras (wide/no-ball) that add runs but are not legal balls. It tracks overs, ends the second innings early once the target is passed, and resolves win, loss or tie. It sits at the top of the scoring datapath and drives the scoreboard display.

Parameters:
OVERS, 20, overs per innings (1..50)
BALLS_PER_OVER, 6, legal balls per over (2..8)
MAX_WICKETS, 10, wickets that end an innings (1..15)
RUN_W, 9, score width in bits; saturating

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
play  input  1  start/resume request; rising edge detected internally
ball_valid  input  1  one delivery presented this cycle
ball_runs  input  3  runs off the delivery, 0..6 (7 treated as 6)
ball_wicket  input  1  wicket fell on this delivery
ball_extra  input  1  wide/no-ball: +1 penalty run, not a legal ball
batting_team  output  1  0 = team 1 batting, 1 = team 2 batting
runs  output  RUN_W  current innings score
wickets  output  4  current innings wickets
ball_count  output  clog2(OVERS*BALLS_PER_OVER+1)  legal balls this innings
over_count  output  6  completed overs this innings
ball_in_over  output  3  legal balls in the current over, 0..BALLS_PER_OVER-1
target  output  RUN_W  team 1 final score + 1 (saturating); 0 until first innings ends
innings_over  output  1  high while in BREAK or DONE
game_over  output  1  high in DONE
winner  output  2  00 = undecided, 01 = team 1, 10 = team 2, 11 = tie

Behaviour:
- Reset (async, any state): FSM goes to IDLE. All outputs, the stored team 1 score and play_q are cleared to 0.
- play_q registers play. start = play & ~play_q. A level held high never advances more than one state.
- FSM states: IDLE, INN1, BREAK, INN2, DONE. All outputs are registered and update on the same edge that accepts a ball.
- IDLE: on start, go to INN1 and clear all counters. batting_team = 0.
- INN1/INN2 accept a ball whenever ball_valid = 1. Each accepted ball updates:
  - runs += ball_runs + ball_extra, saturating at 2^RUN_W-1.
  - If ball_extra = 1: ball_count, over_count, ball_in_over and wickets are unchanged. ball_wicket is ignored.
  - If ball_extra = 0: ball_count += 1 and wickets += ball_wicket. ball_in_over += 1; when it reaches BALLS_PER_OVER it wraps to 0 and over_count += 1.
- Innings termination is evaluated on the post-update values, on the same edge:
  - wickets == MAX_WICKETS, or
  - ball_count == OVERS*BALLS_PER_OVER, or
  - in INN2 only, runs >= target.
- INN1 termination: go to BREAK. Latch team 1 score and set target = runs+1.
- BREAK: ball_valid is ignored and the first-innings counters stay visible. On start, go to INN2, clear runs, wickets, ball_count, over_count and ball_in_over, and set batting_team = 1.
- INN2 termination: go to DONE. winner = 10 if runs >= target; 11 if runs == target-1; else 01.
- DONE: all inputs except rst are ignored and outputs hold.
- winner is 00 in every state except DONE.
- start while in INN1/INN2 has no effect (no pause semantics).
- Simultaneous ball_valid and start in BREAK: start wins and the ball is dropped.
- A final-ball wicket that also completes the overs is a single termination; both counters show their final values.

Test Plan:
1. Defaults. rst, start, 120 legal balls each 1 run, no wickets -> BREAK with runs=120, ball_count=120, over_count=20, ball_in_over=0, target=121, innings_over=1.
2. OVERS=2, BALLS_PER_OVER=6, MAX_WICKETS=2. INN1: two wicket balls on balls 3 and 4 -> BREAK at ball_count=4, wickets=2, over_count=0, ball_in_over=4.
3. Extras. ball_extra=1 with ball_runs=4 -> runs +5, ball_count unchanged, and a simultaneous ball_wicket=1 leaves wickets unchanged.
4. Chase. target=11; INN2 deliveries of 6 then 6 -> DONE after the second ball with runs=12, winner=10, game_over=1; later ball_valid pulses leave outputs unchanged.
5. Tie/loss. With target=11, INN2 runs out of balls at runs=10 -> winner=11. Repeating with final runs=9 -> winner=01.
6. Control and boundaries:
   - play held high from IDLE through INN1's end -> stays in BREAK until play drops and rises again.
   - rst asserted mid-INN2 -> all outputs 0 immediately, without waiting for a clock edge.
   - RUN_W=4 with 20 runs scored -> runs saturates at 15.
